// File: rtl/mobilenetv3_input_scheduler_if.sv
// Memory-read and element-stream bundle between the input scheduler (master)
// and the pixel memory / network input port (slave).
interface mobilenetv3_input_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 18
);
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [7:0]            out_channel;
  logic [7:0]            out_row;
  logic [7:0]            out_col;
  logic                  out_last;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    output out_valid, out_data, out_channel, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    input  out_valid, out_data, out_channel, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/mobilenetv3_input_scheduler.sv
// Walks a stored feature map channel-innermost, reads it through a 1-cycle memory and
// streams tagged elements. Optional perf counters: define MOBILENETV3_SCHED_PERF_EN.
module mobilenetv3_input_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_ROWS   = 224,
  parameter int IMG_COLS   = 224,
  parameter int CHANNELS   = 3,
  parameter int ADDR_WIDTH = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        net_done_i,
  mobilenetv3_input_scheduler_if.master bus,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] frame_count_o,
  output logic [2:0]  state_dbg_o
`ifdef MOBILENETV3_SCHED_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles_o,
  output logic [31:0] perf_frame_cycles_o
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STREAM    = 3'd1,
    DRAIN     = 3'd2,
    WAIT_DONE = 3'd3,
    COMPLETE  = 3'd4
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [7:0]            ch;
    logic [7:0]            row;
    logic [7:0]            col;
    logic                  last;
  } entry_t;

  localparam logic [7:0] CH_LAST  = 8'(CHANNELS - 1);
  localparam logic [7:0] COL_LAST = 8'(IMG_COLS - 1);
  localparam logic [7:0] ROW_LAST = 8'(IMG_ROWS - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            ch_q, col_q, row_q;
  logic                  inflight_q;
  logic [7:0]            if_ch_q, if_col_q, if_row_q;
  logic                  if_last_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;
  logic                  done_q;
  logic [15:0]           frame_count_q;

  logic   pop, push, issue, last_elem;
  logic   [1:0] occ;
  entry_t push_entry, head;

  // Budget counts what the FIFO will hold once every in-flight read lands.
  assign pop        = (count_q != 2'd0) && bus.out_ready;
  assign push       = inflight_q;
  assign occ        = count_q + {1'b0, inflight_q};
  assign issue      = (state_q == STREAM) && (occ < (2'd2 + {1'b0, pop}));
  assign last_elem  = (ch_q == CH_LAST) && (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign push_entry = '{data: bus.mem_rd_data, ch: if_ch_q, row: if_row_q,
                        col: if_col_q, last: if_last_q};

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    entry_t slot_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        slot_q <= '0;
      else if (push && (wr_ptr_q == 1'(gi)))
        slot_q <= push_entry;
    end
  end

  assign head = rd_ptr_q ? g_slot[1].slot_q : g_slot[0].slot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      ch_q          <= '0;
      col_q         <= '0;
      row_q         <= '0;
      inflight_q    <= 1'b0;
      if_ch_q       <= '0;
      if_col_q      <= '0;
      if_row_q      <= '0;
      if_last_q     <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= '0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
    end else if (abort_i) begin
      // Clearing inflight_q drops the data returned for a read issued this cycle.
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        if_ch_q   <= ch_q;
        if_col_q  <= col_q;
        if_row_q  <= row_q;
        if_last_q <= last_elem;
        addr_q    <= addr_q + ADDR_WIDTH'(1);
        if (ch_q == CH_LAST) begin
          ch_q <= '0;
          if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= row_q + 8'd1;
          end else begin
            col_q <= col_q + 8'd1;
          end
        end else begin
          ch_q <= ch_q + 8'd1;
        end
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};

      case (state_q)
        IDLE: if (start_i) begin
          state_q <= STREAM;
          addr_q  <= '0;
          ch_q    <= '0;
          col_q   <= '0;
          row_q   <= '0;
        end
        STREAM:    if (issue && last_elem) state_q <= DRAIN;
        DRAIN:     if ((count_q == 2'd0) && !inflight_q) state_q <= WAIT_DONE;
        WAIT_DONE: if (net_done_i) begin
          state_q       <= COMPLETE;
          done_q        <= 1'b1;
          frame_count_q <= frame_count_q + 16'd1;
        end
        COMPLETE:  state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en   = issue;
  assign bus.mem_addr    = addr_q;
  assign bus.out_valid   = (count_q != 2'd0);
  assign bus.out_data    = head.data;
  assign bus.out_channel = head.ch;
  assign bus.out_row     = head.row;
  assign bus.out_col     = head.col;
  assign bus.out_last    = head.last;

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign frame_count_o = frame_count_q;
  assign state_dbg_o   = state_q;

`ifdef MOBILENETV3_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      frame_cnt_q <= '0;
    end else if ((state_q == IDLE) && start_i && !abort_i) begin
      stall_cnt_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (busy_o && (frame_cnt_q != 32'hFFFF_FFFF))
        frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cycles_o = stall_cnt_q;
  assign perf_frame_cycles_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_mobilenetv3_input_scheduler.sv
// Directed frames with random backpressure and memory contents, checked against a
// queue of expected elements built from the channel/col/row walk order.
module tb_mobilenetv3_input_scheduler;
  localparam int DW = 16;
  localparam int AW = 18;
  localparam int R  = 2;
  localparam int C  = 2;
  localparam int CH = 3;
  localparam int N  = R * C * CH;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [7:0]    ch;
    logic [7:0]    row;
    logic [7:0]    col;
    logic          last;
  } elem_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        net_done = 1'b0;
  logic        busy, done;
  logic [15:0] frame_count;
  logic [2:0]  state_dbg;
`ifdef MOBILENETV3_SCHED_PERF_EN
  logic [31:0] perf_stall, perf_frame;
`endif

  mobilenetv3_input_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mobilenetv3_input_scheduler #(
    .DATA_WIDTH(DW), .IMG_ROWS(R), .IMG_COLS(C), .CHANNELS(CH), .ADDR_WIDTH(AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .abort_i       (abort),
    .net_done_i    (net_done),
    .bus           (bus),
    .busy_o        (busy),
    .done_o        (done),
    .frame_count_o (frame_count),
    .state_dbg_o   (state_dbg)
`ifdef MOBILENETV3_SCHED_PERF_EN
    ,
    .perf_stall_cycles_o (perf_stall),
    .perf_frame_cycles_o (perf_frame)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;

  elem_t         exp_q[$];
  logic [15:0]   mem_base;
  int            issued, popped, stalls, frames, done_cnt;
  int            cyc, first_valid, last_pop, complete_cyc;
  bit            pend, hold, aborted;
  logic [AW-1:0] pend_addr;
  elem_t         held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Expected stream: channel innermost, then col, then row; memory holds base+addr.
  function automatic void build_frame();
    exp_q.delete();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        for (int k = 0; k < CH; k++) begin
          int    a;
          elem_t e;
          a      = (r * C + c) * CH + k;
          e.d    = DW'(int'(mem_base) + a);
          e.ch   = 8'(k);
          e.row  = 8'(r);
          e.col  = 8'(c);
          e.last = (a == N - 1);
          exp_q.push_back(e);
        end
  endfunction

  function automatic bit pick_ready(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return ((k % 4) == 0) || ((k % 4) == 3);
      3:       return !((k >= 3) && (k <= 6));
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // One clock: drive inputs, check the stream at mid-cycle, advance past the edge.
  task automatic cycle(input bit rdy, input int abort_on_read);
    elem_t cur;
    bit    pop, do_abort;
    bus.out_ready   = rdy;
    bus.mem_rd_data = pend ? DW'(mem_base + pend_addr) : '0;
    #1;
    cur = {bus.out_data, bus.out_channel, bus.out_row, bus.out_col, bus.out_last};
    pop = bus.out_valid && rdy;
    if (hold) chk("stall_hold", {bus.out_valid, cur}, {1'b1, held});
    hold = bus.out_valid && !rdy;
    held = cur;
    if (bus.out_valid && !rdy) stalls++;
    if (bus.out_valid && first_valid < 0) first_valid = cyc;
    if (pop) begin
      chk("elem_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("elem", cur, exp_q[0]);
        void'(exp_q.pop_front());
      end
      popped++;
      last_pop = cyc;
    end
    if (bus.mem_rd_en) begin
      chk("rd_addr", bus.mem_addr, issued);
      chk("rd_budget", (issued - popped) < 2, 1);
    end
    if (done) done_cnt++;
    if (state_dbg == 3'd4) complete_cyc = cyc;
    do_abort = bus.mem_rd_en && (issued == abort_on_read);
    if (do_abort) abort = 1'b1;
    pend      = bus.mem_rd_en;
    pend_addr = bus.mem_addr;
    if (pend) issued++;
    cyc++;
    @(posedge clk);
    #1;
    if (do_abort) begin
      abort   = 1'b0;
      exp_q.delete();
      issued  = 0;
      popped  = 0;
      hold    = 1'b0;
      aborted = 1'b1;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_rd_en", bus.mem_rd_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_tags", {bus.out_data, bus.out_channel, bus.out_row, bus.out_col, bus.out_last}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_state", state_dbg, 0);
`ifdef MOBILENETV3_SCHED_PERF_EN
    chk("rst_perf", {perf_stall, perf_frame}, 0);
`endif
  endtask

  task automatic run_frame(input int mode, input bit inject, input int wait_cycles);
    int s, k;
    build_frame();
    first_valid = -1;
    last_pop    = -1;
    stalls      = 0;
    issued      = 0;
    popped      = 0;
    s           = cyc;
    start       = 1'b1;
    cycle(1'b1, -1);
    start = 1'b0;
    chk("start_to_stream", state_dbg, 1);
    chk("busy_in_frame", busy, 1);
    k = 0;
    while (state_dbg != 3'd3 && k < 200) begin
      if (inject && k == 4) begin
        start    = 1'b1;
        net_done = 1'b1;
      end
      cycle(pick_ready(mode, k), -1);
      if (inject && k == 4) begin
        start    = 1'b0;
        net_done = 1'b0;
        chk("inject_ignored", state_dbg, 1);
        chk("inject_no_done", done_cnt, frames);
      end
      k++;
    end
    chk("reach_wait_done", state_dbg, 3);
    chk("all_elems_out", exp_q.size(), 0);
    chk("no_early_done", done_cnt, frames);
    if (mode == 0) begin
      chk("first_valid_lat", first_valid - s, 3);
      chk("one_per_cycle", last_pop - first_valid, N - 1);
    end
    for (int i = 0; i < wait_cycles; i++) begin
      cycle(1'b1, -1);
      chk("wait_done_hold", state_dbg, 3);
    end
    net_done = 1'b1;
    cycle(1'b1, -1);
    net_done = 1'b0;
    frames++;
    chk("complete_state", state_dbg, 4);
    chk("done_high", done, 1);
    cycle(1'b1, -1);
    chk("idle_after_complete", state_dbg, 0);
    chk("done_one_cycle", done, 0);
    chk("busy_low", busy, 0);
    chk("frame_count", frame_count, frames);
    chk("done_pulses", done_cnt, frames);
`ifdef MOBILENETV3_SCHED_PERF_EN
    chk("perf_stall", perf_stall, stalls);
    chk("perf_frame", perf_frame, complete_cyc - s);
    if (mode == 3) chk("perf_stall_4", perf_stall, 4);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_ready   = 1'b0;
    bus.mem_rd_data = '0;
    issued = 0; popped = 0; stalls = 0; frames = 0; done_cnt = 0;
    cyc = 0; first_valid = -1; last_pop = -1; complete_cyc = 0;
    pend = 1'b0; hold = 1'b0; aborted = 1'b0; pend_addr = '0; held = '0;
    mem_base = 16'h0100;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    mem_base = 16'h0100;
    run_frame(0, 1'b0, 10);
    run_frame(1, 1'b0, 3);
    run_frame(3, 1'b0, 3);
    mem_base = 16'($urandom);
    run_frame(2, 1'b1, 2);

    // Abort while the fifth read is being issued, then replay the frame.
    mem_base = 16'($urandom);
    build_frame();
    issued  = 0;
    popped  = 0;
    aborted = 1'b0;
    start   = 1'b1;
    cycle(1'b1, -1);
    start = 1'b0;
    for (int i = 0; i < 20 && !aborted; i++) cycle(1'b1, 4);
    chk("abort_taken", aborted, 1);
    chk("abort_idle", state_dbg, 0);
    chk("abort_no_valid", bus.out_valid, 0);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'($urandom_range(0, 1)), -1);
      chk("abort_discard", {state_dbg, bus.out_valid}, 0);
    end
    chk("abort_no_done", done_cnt, frames);
    chk("abort_frame_count", frame_count, frames);
    run_frame(2, 1'b0, 1);

    // Asynchronous reset in the middle of a streaming frame.
    mem_base = 16'($urandom);
    build_frame();
    issued = 0;
    popped = 0;
    start  = 1'b1;
    cycle(1'b1, -1);
    start = 1'b0;
    for (int i = 0; i < 6; i++) cycle(1'b1, -1);
    chk("pre_reset_streaming", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    pend     = 1'b0;
    hold     = 1'b0;
    frames   = 0;
    done_cnt = 0;
    exp_q.delete();
    mem_base = 16'($urandom);
    run_frame(0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
